// File: rtl/brisc_pkg.sv
// Shared core-wide definitions: datapath width, register-file geometry and
// writeback source identifiers.
package brisc_pkg;

  localparam int XLEN              = 32;
  localparam int REG_NUM_DEFAULT   = 32;
  localparam int REG_WIDTH_DEFAULT = $clog2(REG_NUM_DEFAULT);

  typedef struct packed {
    logic [REG_WIDTH_DEFAULT-1:0] rd;
    logic [XLEN-1:0]              data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_MUL = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after ptr,
// scanning upward modulo N, wins.
import brisc_pkg::*;

module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  logic [IW:0] idx;

  // Walk offsets from farthest to nearest so the nearest active request is
  // the last one to overwrite the result.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IW + 1)'(k);
      if (idx >= (IW + 1)'(N)) begin
        idx = idx - (IW + 1)'(N);
      end
      if (req[idx[IW-1:0]]) begin
        gnt                = '0;
        gnt[idx[IW-1:0]]   = 1'b1;
        gnt_idx            = idx[IW-1:0];
        any_gnt            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the single register-file write port among writeback
// sources, with a one-cycle output register exposed as a decode bypass.
import brisc_pkg::*;

module regfile_wb_arbiter #(
  parameter  int N_REQ      = 3,
  parameter  int REG_LENGTH = XLEN,
  parameter  int REG_NUM    = REG_NUM_DEFAULT,
  localparam int REG_WIDTH  = $clog2(REG_NUM),
  parameter  int CNT_WIDTH  = 32,
  localparam int PW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ-1:0][REG_WIDTH-1:0]      req_rd,
  input  logic [N_REQ-1:0][REG_LENGTH-1:0]     req_data,
  output logic [N_REQ-1:0]                     req_ready,
  output logic [REG_WIDTH-1:0]                 rf_rd_addr,
  output logic [REG_LENGTH-1:0]                rf_write_data,
  output logic                                 rf_enable,
  output logic                                 byp_valid,
  output logic [REG_WIDTH-1:0]                 byp_rd,
  output logic [REG_LENGTH-1:0]                byp_data,
  output logic [CNT_WIDTH-1:0]                 conflict_cnt
);

  logic                  out_valid_q, out_valid_d;
  logic [REG_WIDTH-1:0]  out_rd_q, out_rd_d;
  logic [REG_LENGTH-1:0] out_data_q, out_data_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    gnt_idx;
  logic             any_gnt;
  logic             multi_valid;

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_valid = |(req_valid & (req_valid - N_REQ'(1)));

  always_comb begin
    out_valid_d    = any_gnt;
    out_rd_d       = out_rd_q;
    out_data_d     = out_data_q;
    rr_ptr_d       = rr_ptr_q;
    conflict_cnt_d = conflict_cnt_q;
    if (any_gnt) begin
      out_rd_d   = req_rd[gnt_idx];
      out_data_d = req_data[gnt_idx];
      rr_ptr_d   = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
    end
    if (multi_valid && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_rd_q       <= '0;
      out_data_q     <= '0;
      rr_ptr_q       <= '0;
      conflict_cnt_q <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_rd_q       <= out_rd_d;
      out_data_q     <= out_data_d;
      rr_ptr_q       <= rr_ptr_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Grants are suppressed while reset is held so no requester sees a phantom accept.
  assign req_ready     = reset ? '0 : gnt;
  assign rf_enable     = out_valid_q && (out_rd_q != '0);
  assign rf_rd_addr    = out_rd_q;
  assign rf_write_data = out_data_q;
  assign byp_valid     = rf_enable;
  assign byp_rd        = out_rd_q;
  assign byp_data      = out_data_q;
  assign conflict_cnt  = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_regfile_wb_arbiter;
  import brisc_pkg::*;

  localparam int N  = 3;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N-1:0]           req_valid;
  logic [N-1:0][RW-1:0]   req_rd;
  logic [N-1:0][DW-1:0]   req_data;
  logic [N-1:0]           req_ready;
  logic [RW-1:0]          rf_rd_addr;
  logic [DW-1:0]          rf_write_data;
  logic                   rf_enable;
  logic                   byp_valid;
  logic [RW-1:0]          byp_rd;
  logic [DW-1:0]          byp_data;
  logic [CW-1:0]          conflict_cnt;

  regfile_wb_arbiter #(
    .N_REQ(N), .REG_LENGTH(DW), .REG_NUM(32), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(req_ready), .rf_rd_addr(rf_rd_addr),
    .rf_write_data(rf_write_data), .rf_enable(rf_enable), .byp_valid(byp_valid),
    .byp_rd(byp_rd), .byp_data(byp_data), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [N-1:0] gq[$];
  wr_t          wq[$];
  int           m_ptr;
  int           m_cnt;
  int           exp_cnt_now;
  logic [DW-1:0] m_rf[32];
  logic [DW-1:0] dut_rf[32];
  bit           infl_v;
  wr_t          infl;
  wr_t          mon_w;
  int           last_gnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One arbitration cycle: apply inputs, then advance the reference model.
  task automatic drive_cycle(input logic [N-1:0] v, input logic [N-1:0][RW-1:0] rd,
                             input logic [N-1:0][DW-1:0] d);
    @(posedge clk);
    #1;
    cyc++;
    if (infl_v) m_rf[infl.rd] = infl.data;
    infl_v      = 1'b0;
    exp_cnt_now = m_cnt;
    req_valid   = v;
    req_rd      = rd;
    req_data    = d;
    last_gnt    = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i] && last_gnt < 0) last_gnt = i;
    end
    gq.push_back(last_gnt < 0 ? N'(0) : (N'(1) << last_gnt));
    if (last_gnt >= 0) begin
      m_ptr = (last_gnt + 1) % N;
      if (rd[last_gnt] != 0) begin
        infl_v    = 1'b1;
        infl.rd   = rd[last_gnt];
        infl.data = d[last_gnt];
        wq.push_back(infl);
      end
    end
    if ($countones(v) >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
    if (last_gnt >= 0)
      $display("cycle %0d: valid=%b grant=%0d rd=%0d data=0x%08h", cyc, v, last_gnt,
               rd[last_gnt], d[last_gnt]);
    else
      $display("cycle %0d: valid=%b no grant", cyc, v);
  endtask

  task automatic idle();
    drive_cycle('0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (gq.size() > 0) check("req_ready", req_ready, gq.pop_front());
      check("conflict_cnt", conflict_cnt, exp_cnt_now);
      if (rf_enable) begin
        if (wq.size() == 0) begin
          check("rf_enable_unexpected", rf_enable, 0);
        end else begin
          mon_w = wq.pop_front();
          check("rf_rd_addr", rf_rd_addr, mon_w.rd);
          check("rf_write_data", rf_write_data, mon_w.data);
          check("byp_valid", byp_valid, 1);
          check("byp_rd", byp_rd, mon_w.rd);
          check("byp_data", byp_data, mon_w.data);
        end
        dut_rf[rf_rd_addr] = rf_write_data;
      end else begin
        check("byp_valid_idle", byp_valid, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]         v;
    logic [N-1:0][RW-1:0] rd;
    logic [N-1:0][DW-1:0] d;
    logic [N-1:0]         pv;
    logic [N-1:0][RW-1:0] prd;
    logic [N-1:0][DW-1:0] pd;

    reset = 1'b1;
    req_valid = '0; req_rd = '0; req_data = '0;
    m_ptr = 0; m_cnt = 0; exp_cnt_now = 0; infl_v = 1'b0;
    for (int r = 0; r < 32; r++) begin m_rf[r] = '0; dut_rf[r] = '0; end

    // Outputs and grants stay quiet while reset is held, even with all requesters valid.
    @(posedge clk); #1;
    req_valid = '1;
    req_rd    = {5'd3, 5'd2, 5'd1};
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rf_enable", rf_enable, 0);
    check("rst_rf_rd_addr", rf_rd_addr, 0);
    check("rst_rf_write_data", rf_write_data, 0);
    check("rst_byp_valid", byp_valid, 0);
    check("rst_byp_data", byp_data, 0);
    @(posedge clk); #1;
    check("rst_conflict_cnt", conflict_cnt, 0);
    req_valid = '0;
    reset = 1'b0;

    // Fairness: all three valid for 6 cycles.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        rd[i] = RW'(10 + i);
        d[i]  = DW'(c * 16 + i + 1);
      end
      drive_cycle('1, rd, d);
    end
    idle();
    check("fair_conflict_cnt", conflict_cnt, 6);

    // Single ALU request.
    v = '0; rd = '0; d = '0;
    v[WB_ALU] = 1'b1; rd[WB_ALU] = 5'd5; d[WB_ALU] = 32'hDEADBEEF;
    drive_cycle(v, rd, d);
    #1 check("single_ready", req_ready, 3'b001);
    idle();
    check("single_rf_enable", rf_enable, 1);
    check("single_rf_rd_addr", rf_rd_addr, 5);
    check("single_rf_data", rf_write_data, 32'hDEADBEEF);
    check("single_byp_valid", byp_valid, 1);
    idle();
    check("single_rf_enable_off", rf_enable, 0);

    // x0 write from MEM: accepted but filtered.
    v = '0; rd = '0; d = '0;
    v[WB_MEM] = 1'b1; rd[WB_MEM] = 5'd0; d[WB_MEM] = 32'h1234;
    drive_cycle(v, rd, d);
    idle();
    check("x0_rf_enable", rf_enable, 0);
    check("x0_byp_valid", byp_valid, 0);
    drive_cycle('1, {5'd9, 5'd8, 5'd6}, {32'h9, 32'h8, 32'h6});
    #1 check("x0_ptr_advanced", req_ready, 3'b100);

    // Same rd from ALU and MUL with pointer at 0.
    drive_cycle(3'b101, {5'd7, 5'd0, 5'd7}, {32'h2, 32'h0, 32'h1});
    drive_cycle(3'b100, {5'd7, 5'd0, 5'd0}, {32'h2, 32'h0, 32'h0});
    idle();
    idle();
    check("same_rd_final", dut_rf[7], 32'h2);

    // Random traffic; a pending request holds until it is granted.
    pv = '0; prd = '0; pd = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i]  = 1'b1;
          prd[i] = RW'($urandom_range(0, 31));
          pd[i]  = $urandom;
        end
      end
      drive_cycle(pv, prd, pd);
      if (last_gnt >= 0) pv[last_gnt] = 1'b0;
    end

    // Reset while a write is in flight.
    drive_cycle(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'hABCD});
    @(posedge clk); #1;
    check("pre_reset_rf_enable", rf_enable, 1);
    reset = 1'b1;
    req_valid = '1;
    #1;
    check("async_rst_rf_enable", rf_enable, 0);
    check("async_rst_byp_valid", byp_valid, 0);
    check("async_rst_req_ready", req_ready, 0);
    check("async_rst_conflict_cnt", conflict_cnt, 0);
    wq.delete();
    gq.delete();
    infl_v = 1'b0;
    m_ptr = 0; m_cnt = 0; exp_cnt_now = 0;
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b0;
    drive_cycle('1, {5'd21, 5'd22, 5'd23}, {32'h21, 32'h22, 32'h23});
    #1 check("post_reset_first_grant", req_ready, 3'b001);

    // Saturation of the 4-bit conflict counter.
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) begin
        rd[i] = RW'($urandom_range(1, 31));
        d[i]  = $urandom;
      end
      drive_cycle('1, rd, d);
    end
    idle();
    check("sat_conflict_cnt", conflict_cnt, 4'hF);
    idle();
    idle();

    check("pending_writes", wq.size(), 0);
    for (int r = 1; r < 32; r++) check($sformatf("rf_x%0d", r), dut_rf[r], m_rf[r]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (rd address, write data, write enable) among N_REQ writeback sources, e.g. ALU, load/store and multiplier, using valid/ready handshakes and round-robin arbitration.
- Registers the granted write for one cycle before it reaches the register file.
- Exposes that in-flight write so decode can bypass it.
- Counts arbitration-conflict cycles for performance analysis.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8).
- REG_LENGTH, XLEN, data width in bits.
- REG_NUM, 32, number of architectural registers.
- REG_WIDTH, $clog2(REG_NUM), register-address width; derived, not overridable.
- CNT_WIDTH, 32, width of the conflict counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a write pending.
- req_rd  in  N_REQ x REG_WIDTH  destination register per requester.
- req_data  in  N_REQ x REG_LENGTH  write data per requester.
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- rf_rd_addr  out  REG_WIDTH  register-file write address.
- rf_write_data  out  REG_LENGTH  register-file write data.
- rf_enable  out  1  register-file write enable.
- byp_valid  out  1  an in-flight write to a nonzero rd is visible this cycle.
- byp_rd  out  REG_WIDTH  rd of the in-flight write.
- byp_data  out  REG_LENGTH  data of the in-flight write.
- conflict_cnt  out  CNT_WIDTH  saturating count of cycles with at least two valid requesters.

Behaviour:
- Reset (asynchronous assert): out_valid=0, out_rd=0, out_data=0, rr_ptr=0, conflict_cnt=0. All outputs are therefore 0 during reset, and req_ready is all-zero while reset is high.
- Arbitration (combinational):
  - Scan requesters from rr_ptr upward, modulo N_REQ. The first i with req_valid[i]=1 wins and gets req_ready[i]=1.
  - req_ready is at most one-hot and all-zero when no request is valid.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- rr_ptr update (clocked): on a grant to i, rr_ptr <= (i+1) mod N_REQ. With no grant, rr_ptr holds. This bounds any requester's wait to N_REQ-1 cycles while it is continuously valid.
- Output stage (clocked):
  - On a grant: out_valid<=1, out_rd<=req_rd[i], out_data<=req_data[i].
  - Otherwise: out_valid<=0; out_rd and out_data hold.
- Latency: a grant in cycle t produces rf_enable=1 in cycle t+1, so the register file captures the write at the end of t+1. Throughput is one write per cycle.
- Write port drive: rf_enable = out_valid && (out_rd != 0). rf_rd_addr=out_rd and rf_write_data=out_data.
- Writes to x0: the transfer is accepted (ready given, pointer advances) but never reaches the register file. byp_valid is also low for it.
- Bypass: byp_valid = rf_enable, byp_rd=out_rd, byp_data=out_data. Decode uses these because a register-file read in cycle t+1 still returns the old value.
- Same rd from two requesters in one cycle: the arbitration winner is written first and the other in a later cycle, so the later grant is the final value. Upstream must not issue same-rd writes whose order matters.
- Back-to-back writes: a same-rd write in t+1 is legal. The bypass shows the newest in-flight value.
- conflict_cnt: increments when popcount(req_valid) >= 2 and saturates at all-ones with no wrap.
- Reset asserted mid-transfer: the in-flight out_valid write is discarded (rf_enable drops asynchronously) and arbitration state is lost.

Decomposition:
- brisc_pkg holds:
  - XLEN, already present.
  - REG_NUM_DEFAULT=32.
  - a wb_req_t struct {rd, data}.
  - a wb_src_e enum (WB_ALU, WB_MEM, WB_MUL) for requester indices.
- Sub-module rr_arbiter (N, req, ptr -> one-hot gnt, gnt_idx, any_gnt), reusable for later arbiters. The output register, pointer update and counter stay in regfile_wb_arbiter.

Test Plan:
- Single request: ALU only, rd=5, data=0xDEADBEEF in cycle 1 -> req_ready[0]=1 in cycle 1; cycle 2 rf_enable=1, rf_rd_addr=5, rf_write_data=0xDEADBEEF, byp_valid=1; cycle 3 rf_enable=0.
- Round-robin fairness: all 3 requesters valid continuously for 6 cycles after reset -> grant order 0,1,2,0,1,2; conflict_cnt=6 afterwards.
- x0 filtering: MEM writes rd=0, data=0x1234 -> req_ready[1]=1, next cycle rf_enable=0 and byp_valid=0, rr_ptr=2.
- Same-rd ordering: ALU and MUL both write rd=7 (0x1 and 0x2) with rr_ptr=0 -> rd7 written 0x1 then 0x2; register-file read of rd7 after both returns 0x2.
- Reset mid-operation: assert reset while out_valid=1 -> rf_enable falls without waiting for a clock edge; after release, first grant goes to requester 0 and conflict_cnt=0.
- Saturation: run with CNT_WIDTH=4 and 20 conflict cycles -> conflict_cnt stays at 0xF.
